// File: rtl/sdram_arb.sv
// sdram_arb: two-port request arbiter in front of a single-request SDRAM
// controller. One transaction is in flight at a time:
//   IDLE  -> grant a port and latch its request fields
//   ISSUE -> strobe (mem_rd or mem_we) is high, controller sees rising edge
//   WAIT  -> strobe held until mem_ready, then ack the granted port
// Optional feature: define SDRAM_ARB_RR_EN for round-robin arbitration;
// without it port 0 always wins a conflict and no pointer register exists.
module sdram_arb (
    input  logic        clk,
    input  logic        init,

    input  logic        p0_req,
    input  logic        p0_we,
    input  logic [26:0] p0_addr,
    input  logic [15:0] p0_din,
    input  logic [1:0]  p0_wtbt,
    output logic        p0_ack,
    output logic [15:0] p0_dout,

    input  logic        p1_req,
    input  logic        p1_we,
    input  logic [26:0] p1_addr,
    input  logic [15:0] p1_din,
    input  logic [1:0]  p1_wtbt,
    output logic        p1_ack,
    output logic [15:0] p1_dout,

    output logic [26:0] mem_addr,
    output logic [15:0] mem_din,
    output logic [1:0]  mem_wtbt,
    output logic        mem_we,
    output logic        mem_rd,
    input  logic [15:0] mem_dout,
    input  logic        mem_ready
);

    localparam logic [1:0] ST_IDLE  = 2'd0;
    localparam logic [1:0] ST_ISSUE = 2'd1;
    localparam logic [1:0] ST_WAIT  = 2'd2;

    logic [1:0]  state_r;
    logic [1:0]  state_nxt_s;
    logic        gnt_r;          // port owning the transaction in flight
    logic        grant_s;        // a port is granted this cycle
    logic        sel_s;          // which port wins if granted
    logic        prio_s;         // port preferred on a conflict
    logic        done_s;         // controller completes this cycle
    logic        any_req_s;
    logic        ack_busy_s;
    logic        sel_we_s;
    logic [26:0] sel_addr_s;
    logic [15:0] sel_din_s;
    logic [1:0]  sel_wtbt_s;

    // Conflict resolution: on a double request the preferred port wins,
    // otherwise whichever port is requesting.
    function automatic logic pick_port(input logic r0, input logic r1, input logic prio);
        logic sel;
        if (r0 && r1) begin
            sel = prio;
        end else if (r1) begin
            sel = 1'b1;
        end else begin
            sel = 1'b0;
        end
        return sel;
    endfunction

`ifdef SDRAM_ARB_RR_EN
    logic prio_r;                // port that wins the next conflict

    assign prio_s = prio_r;

    // Round-robin pointer: after every grant the other port gets preference.
    always_ff @(posedge clk) begin
        if (init) begin
            prio_r <= 1'b0;
        end else if (grant_s) begin
            prio_r <= ~sel_s;
        end
    end
`else
    assign prio_s = 1'b0;
`endif

    assign done_s = (state_r == ST_WAIT) && mem_ready;

    // Grant decision. No grant while an ack is showing: the acked port's req
    // is still the old request during that cycle, and skipping the cycle also
    // guarantees a low strobe gap between transactions.
    always_comb begin
        any_req_s  = p0_req || p1_req;
        ack_busy_s = p0_ack || p1_ack;
        sel_s      = pick_port(p0_req, p1_req, prio_s);
        if ((state_r == ST_IDLE) && mem_ready && any_req_s && !ack_busy_s) begin
            grant_s = 1'b1;
        end else begin
            grant_s = 1'b0;
        end
    end

    // Request field mux for the winning port.
    always_comb begin
        if (sel_s) begin
            sel_we_s   = p1_we;
            sel_addr_s = p1_addr;
            sel_din_s  = p1_din;
            sel_wtbt_s = p1_wtbt;
        end else begin
            sel_we_s   = p0_we;
            sel_addr_s = p0_addr;
            sel_din_s  = p0_din;
            sel_wtbt_s = p0_wtbt;
        end
    end

    // Next-state logic; mem_ready is deliberately ignored in ISSUE.
    always_comb begin
        state_nxt_s = state_r;
        case (state_r)
            ST_IDLE: begin
                if (grant_s) begin
                    state_nxt_s = ST_ISSUE;
                end else begin
                    state_nxt_s = ST_IDLE;
                end
            end
            ST_ISSUE: begin
                state_nxt_s = ST_WAIT;
            end
            ST_WAIT: begin
                if (mem_ready) begin
                    state_nxt_s = ST_IDLE;
                end else begin
                    state_nxt_s = ST_WAIT;
                end
            end
            default: begin
                state_nxt_s = ST_IDLE;
            end
        endcase
    end

    // State register.
    always_ff @(posedge clk) begin
        if (init) begin
            state_r <= ST_IDLE;
        end else begin
            state_r <= state_nxt_s;
        end
    end

    // Remember which port owns the transaction so completion goes to it.
    always_ff @(posedge clk) begin
        if (init) begin
            gnt_r <= 1'b0;
        end else if (grant_s) begin
            gnt_r <= sel_s;
        end
    end

    // Request fields are captured once at grant and held until the next grant.
    always_ff @(posedge clk) begin
        if (init) begin
            mem_addr <= 27'd0;
            mem_din  <= 16'd0;
            mem_wtbt <= 2'd0;
        end else if (grant_s) begin
            mem_addr <= sel_addr_s;
            mem_din  <= sel_din_s;
            mem_wtbt <= sel_wtbt_s;
        end
    end

    // Strobes rise on grant, hold through ISSUE and WAIT, drop on completion.
    always_ff @(posedge clk) begin
        if (init) begin
            mem_we <= 1'b0;
            mem_rd <= 1'b0;
        end else if (grant_s) begin
            mem_we <= sel_we_s;
            mem_rd <= ~sel_we_s;
        end else if ((state_r == ST_ISSUE) || ((state_r == ST_WAIT) && !mem_ready)) begin
            mem_we <= mem_we;
            mem_rd <= mem_rd;
        end else begin
            mem_we <= 1'b0;
            mem_rd <= 1'b0;
        end
    end

    // One-cycle ack to the owning port on completion.
    always_ff @(posedge clk) begin
        if (init) begin
            p0_ack <= 1'b0;
            p1_ack <= 1'b0;
        end else begin
            p0_ack <= done_s && !gnt_r;
            p1_ack <= done_s && gnt_r;
        end
    end

    // Read data lands only in the owning port, and only for reads.
    always_ff @(posedge clk) begin
        if (init) begin
            p0_dout <= 16'd0;
            p1_dout <= 16'd0;
        end else if (done_s && mem_rd) begin
            if (gnt_r) begin
                p1_dout <= mem_dout;
            end else begin
                p0_dout <= mem_dout;
            end
        end
    end

endmodule
